clk_src_selector: RTL and testbench
===================================

# clk_src_selector

Parametrised input-clock source selector and MMCM lock supervisor for the clocking-wizard front end. Monitors up to N candidate clock sources and picks the highest-priority live one. It then drives the glitch-safe select and the MMCM reset, waits for lock with a timeout, and fails over automatically on source loss, lock loss, or pre-emption. All logic runs in one free-running reference clock domain. Source activity arrives as per-source toggle signals generated in each source domain.

## Interface
- N_SRC, 2: number of candidate sources; index 0 has the highest priority.
- ACT_WINDOW, 64: activity measurement window, in ref_clk cycles.
- ACT_MIN, 4: minimum toggle edges per window for a source to count as present.
- RST_CYC, 8: MMCM reset pulse length after a source is selected.
- LOCK_TIMEOUT, 100: ref_clk cycles allowed for lock after reset release.
- HOLDOFF_CYC, 16: quiet time with the mux gated off before reselection.
- PREEMPT, 1: 1 means a higher-priority source becoming present forces a switch away from a locked lower-priority source.
- ref_clk  in  1  free-running reference clock; the only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- src_toggle  in  N_SRC  per-source divide-by-2 toggle from each source domain; asynchronous.
- mmcm_locked  in  1  MMCM locked output; asynchronous.
- sel  out  $clog2(N_SRC) (minimum 1)  index of the selected source, for the clk_in mux.
- sel_valid  out  1  mux enable; 0 gates the MMCM input to constant 0.
- mmcm_reset  out  1  MMCM reset.
- locked_out  out  1  selected source is running and the MMCM is locked.
- src_present  out  N_SRC  registered per-source activity status.
- src_masked  out  N_SRC  sources blacklisted after a lock timeout.
- timeout_pulse  out  1  one-cycle pulse when a lock timeout occurs.

## Operation
- Activity detection runs per source:
  - 2-FF synchroniser on src_toggle, then a third flop for edge detect (any transition counts).
  - A saturating edge counter of width $clog2(ACT_WINDOW+1).
  - A shared window counter runs 0..ACT_WINDOW-1. At the last count, each src_present[i] <= (edge_cnt[i] >= ACT_MIN) and all edge counters clear.
  - src_present changes only at window boundaries.
- mmcm_locked passes through a 2-FF synchroniser to give lock_s.
- Eligible sources are src_present & ~src_masked. The candidate is the lowest eligible index.
- FSM states, encoded in the package:
  - IDLE: sel_valid=0, mmcm_reset=1. When any source is eligible, latch sel=candidate and go to ARM.
  - ARM: sel_valid=1, mmcm_reset=1 for RST_CYC cycles, then go to WAIT_LOCK with the counter cleared.
  - WAIT_LOCK: mmcm_reset=0; the counter increments each cycle. Exits are checked in priority order:
    - Selected source not present: go to HOLDOFF.
    - lock_s=1: go to LOCKED.
    - Counter reaches LOCK_TIMEOUT-1: set src_masked[sel], pulse timeout_pulse, go to HOLDOFF.
  - LOCKED: locked_out=1. Exits, any of which goes to HOLDOFF:
    - lock_s=0.
    - Selected source not present.
    - PREEMPT=1 and candidate < sel.
  - HOLDOFF: sel_valid=0, mmcm_reset=1 for HOLDOFF_CYC cycles, then go to IDLE.
- sel changes only in IDLE, so sel never changes while sel_valid=1.
- src_masked[i] clears on the cycle src_present[i] falls. A source must therefore disappear and reappear before it is retried.

## Timing
- Reset values: sel=0, sel_valid=0, mmcm_reset=1, locked_out=0, src_present=0, src_masked=0, timeout_pulse=0, state=IDLE, all counters 0.
- All outputs are registered. An FSM decision takes effect on outputs in the next ref_clk cycle.
- Toggle to edge-detect latency is 3 cycles. Worst-case presence detection is 2×ACT_WINDOW+3 cycles.
- mmcm_locked to locked_out latency is 3 cycles (2 sync + FSM).
- sel_valid goes low in the same cycle the FSM enters HOLDOFF. It stays low for HOLDOFF_CYC cycles plus at least 1 IDLE cycle before sel can change.
- Simultaneous events:
  - Source loss wins over lock or timeout in WAIT_LOCK: no mask, no pulse.
  - Timeout and lock in the same cycle: lock wins.
- Reset asserted mid-operation returns every output to its reset value immediately. Synchroniser and window state also clear.

## Structure
- The package clk_src_pkg holds the state enum (IDLE, ARM, WAIT_LOCK, LOCKED, HOLDOFF) and a function for the lowest-set-bit priority encoder.
- The sub-module clk_src_activity (one instance per source) contains the synchroniser, edge detect and saturating edge counter. It takes the shared window-end strobe and outputs present.
- The top level holds the window counter, lock synchroniser, FSM, masks and one shared counter reused for ARM, WAIT_LOCK and HOLDOFF.

## Test plan
All scenarios use N_SRC=2, ACT_WINDOW=64, ACT_MIN=4, RST_CYC=8, LOCK_TIMEOUT=100, HOLDOFF_CYC=16, PREEMPT=1.
- Only src 1 toggling every 4 cycles, mmcm_locked asserted 40 cycles after mmcm_reset falls -> sel=1, sel_valid=1, mmcm_reset high for exactly 8 cycles, locked_out=1 three cycles after lock.
- Locked on src 1, then src 0 starts toggling -> after the next window, HOLDOFF (sel_valid=0 for 16 cycles), then sel=0 and relock.
- src 0 present, mmcm_locked never asserts -> timeout_pulse after 100 WAIT_LOCK cycles, src_masked=2'b01, falls back to src 1 if present.
- Locked on src 0, src 0 toggles stop -> src_present[0]=0 within 2 windows, locked_out=0, src_masked[0] clears, src 1 selected.
- Source with only 3 edges per window -> src_present stays 0, FSM stays in IDLE with mmcm_reset=1.
- Reset asserted while in LOCKED -> all outputs return to reset values immediately. After release, the full sequence restarts from IDLE.

Source files
------------

// File: rtl/clk_src_pkg.sv
// Shared definitions for the clock source selector.
//   state_t    : supervisor FSM states
//   lowest_set : priority encoder, returns the index of the lowest set bit (0 if none)
package clk_src_pkg;

    localparam int MAX_SRC = 32;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_LOCK,
        LOCKED,
        HOLDOFF
    } state_t;

    function automatic int unsigned lowest_set(input logic [MAX_SRC-1:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (vec[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/clk_src_selector_activity.sv
// Per-source activity detector.
// Ports:
//   ref_clk  in  reference clock
//   reset    in  async active-high reset
//   toggle   in  divide-by-2 toggle from the source domain (asynchronous)
//   win_end  in  strobe on the last cycle of the shared measurement window
//   present  out registered: at least ACT_MIN edges seen in the last window
module clk_src_selector_activity #(
    parameter int ACT_WINDOW = 64,
    parameter int ACT_MIN    = 4
) (
    input  logic ref_clk,
    input  logic reset,
    input  logic toggle,
    input  logic win_end,
    output logic present
);

    localparam int CNT_W = $clog2(ACT_WINDOW + 1);

    logic             sync_1, sync_2, sync_3;
    logic             edge_seen;
    logic [CNT_W-1:0] edge_cnt;

    // Both toggle directions count, so one edge per source-clock period.
    assign edge_seen = sync_2 ^ sync_3;

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            sync_3   <= 1'b0;
            edge_cnt <= '0;
            present  <= 1'b0;
        end else begin
            sync_1 <= toggle;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
            if (win_end) begin
                present  <= (edge_cnt >= CNT_W'(ACT_MIN));
                edge_cnt <= '0;
            end else if (edge_seen && (edge_cnt != '1)) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_src_selector.sv
// Input clock source selector and MMCM lock supervisor.
// Picks the lowest-index live, unmasked source, drives the mux select and
// MMCM reset, waits for lock with a timeout and fails over on loss/pre-emption.
// Ports:
//   ref_clk        in   free-running reference clock
//   reset          in   async active-high reset
//   src_toggle     in   per-source toggle, asynchronous
//   mmcm_locked    in   MMCM lock, asynchronous
//   sel            out  selected source index
//   sel_valid      out  mux enable (0 gates MMCM input to 0)
//   mmcm_reset     out  MMCM reset
//   locked_out     out  selected source running and MMCM locked
//   src_present    out  per-source activity status
//   src_masked     out  sources blacklisted after a lock timeout
//   timeout_pulse  out  one-cycle pulse on lock timeout
//
// state     | meaning
// IDLE      | mux gated, MMCM in reset, waiting for an eligible source
// ARM       | mux enabled on sel, MMCM held in reset for RST_CYC cycles
// WAIT_LOCK | MMCM released, waiting up to LOCK_TIMEOUT cycles for lock
// LOCKED    | running; leaves on lock loss, source loss or pre-emption
// HOLDOFF   | mux gated, MMCM in reset for HOLDOFF_CYC cycles
module clk_src_selector
    import clk_src_pkg::*;
#(
    parameter int N_SRC        = 2,
    parameter int ACT_WINDOW   = 64,
    parameter int ACT_MIN      = 4,
    parameter int RST_CYC      = 8,
    parameter int LOCK_TIMEOUT = 100,
    parameter int HOLDOFF_CYC  = 16,
    parameter int PREEMPT      = 1,
    localparam int SEL_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             ref_clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_toggle,
    input  logic             mmcm_locked,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             mmcm_reset,
    output logic             locked_out,
    output logic [N_SRC-1:0] src_present,
    output logic [N_SRC-1:0] src_masked,
    output logic             timeout_pulse
);

    localparam int WIN_W   = (ACT_WINDOW > 1) ? $clog2(ACT_WINDOW) : 1;
    localparam int CNT_MAX = (RST_CYC > LOCK_TIMEOUT)
                             ? ((RST_CYC > HOLDOFF_CYC) ? RST_CYC : HOLDOFF_CYC)
                             : ((LOCK_TIMEOUT > HOLDOFF_CYC) ? LOCK_TIMEOUT : HOLDOFF_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [WIN_W-1:0] win_cnt;
    logic             win_end;
    logic             lock_m, lock_s;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [SEL_W-1:0] sel_n, cand;
    logic [N_SRC-1:0] eligible;
    logic             sel_present;
    logic             timeout_n;

    assign win_end = (win_cnt == WIN_W'(ACT_WINDOW - 1));

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            win_cnt <= '0;
        end else if (win_end) begin
            win_cnt <= '0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < N_SRC; i++) begin : g_act
        clk_src_selector_activity #(
            .ACT_WINDOW (ACT_WINDOW),
            .ACT_MIN    (ACT_MIN)
        ) u_act (
            .ref_clk (ref_clk),
            .reset   (reset),
            .toggle  (src_toggle[i]),
            .win_end (win_end),
            .present (src_present[i])
        );
    end

    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= mmcm_locked;
            lock_s <= lock_m;
        end
    end

    assign eligible    = src_present & ~src_masked;
    assign cand        = SEL_W'(lowest_set(MAX_SRC'(eligible)));
    assign sel_present = src_present[sel];

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sel_n     = sel;
        timeout_n = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (|eligible) begin
                    sel_n   = cand;
                    state_n = ARM;
                end
            end
            ARM: begin
                if (cnt == CNT_W'(RST_CYC - 1)) begin
                    cnt_n   = '0;
                    state_n = WAIT_LOCK;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                // Source loss outranks lock, and lock outranks timeout.
                if (!sel_present) begin
                    cnt_n   = '0;
                    state_n = HOLDOFF;
                end else if (lock_s) begin
                    cnt_n   = '0;
                    state_n = LOCKED;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_n     = '0;
                    timeout_n = 1'b1;
                    state_n   = HOLDOFF;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LOCKED: begin
                cnt_n = '0;
                if (!lock_s || !sel_present ||
                    ((PREEMPT != 0) && (|eligible) && (cand < sel))) begin
                    state_n = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (cnt == CNT_W'(HOLDOFF_CYC - 1)) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move with the transition.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            sel           <= '0;
            sel_valid     <= 1'b0;
            mmcm_reset    <= 1'b1;
            locked_out    <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            sel           <= sel_n;
            sel_valid     <= (state_n == ARM) || (state_n == WAIT_LOCK) || (state_n == LOCKED);
            mmcm_reset    <= (state_n == IDLE) || (state_n == ARM) || (state_n == HOLDOFF);
            locked_out    <= (state_n == LOCKED);
            timeout_pulse <= timeout_n;
        end
    end

    // A mask only lifts once its source has been seen absent, so a timed-out
    // source must drop out and come back before it is retried.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            src_masked <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (!src_present[i]) begin
                    src_masked[i] <= 1'b0;
                end else if (timeout_n && (sel == SEL_W'(i))) begin
                    src_masked[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_src_selector.sv
module tb_clk_src_selector;

    localparam int N_SRC        = 2;
    localparam int ACT_WINDOW   = 64;
    localparam int ACT_MIN      = 4;
    localparam int RST_CYC      = 8;
    localparam int LOCK_TIMEOUT = 100;
    localparam int HOLDOFF_CYC  = 16;
    localparam int PREEMPT      = 1;

    logic       ref_clk     = 1'b0;
    logic       reset       = 1'b1;
    logic [1:0] src_toggle  = 2'b00;
    logic       mmcm_locked = 1'b0;
    logic [0:0] sel;
    logic       sel_valid, mmcm_reset, locked_out, timeout_pulse;
    logic [1:0] src_present, src_masked;

    clk_src_selector #(
        .N_SRC        (N_SRC),
        .ACT_WINDOW   (ACT_WINDOW),
        .ACT_MIN      (ACT_MIN),
        .RST_CYC      (RST_CYC),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .HOLDOFF_CYC  (HOLDOFF_CYC),
        .PREEMPT      (PREEMPT)
    ) dut (
        .ref_clk       (ref_clk),
        .reset         (reset),
        .src_toggle    (src_toggle),
        .mmcm_locked   (mmcm_locked),
        .sel           (sel),
        .sel_valid     (sel_valid),
        .mmcm_reset    (mmcm_reset),
        .locked_out    (locked_out),
        .src_present   (src_present),
        .src_masked    (src_masked),
        .timeout_pulse (timeout_pulse)
    );

    always #5 ref_clk = ~ref_clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- stimulus generators ----------------
    int tog_period[2] = '{0, 0};
    int tog_cnt[2]    = '{0, 0};
    int lock_mode     = 0;
    int lock_cnt      = 0;

    initial forever begin
        @(negedge ref_clk);
        for (int i = 0; i < 2; i++) begin
            if (tog_period[i] == 0) begin
                tog_cnt[i] = 0;
            end else begin
                tog_cnt[i]++;
                if (tog_cnt[i] >= tog_period[i]) begin
                    tog_cnt[i]    = 0;
                    src_toggle[i] = ~src_toggle[i];
                end
            end
        end
    end

    // MMCM stand-in: locks 40 cycles after its reset is released.
    initial forever begin
        @(negedge ref_clk);
        if (mmcm_reset || (lock_mode == 0)) begin
            lock_cnt    = 0;
            mmcm_locked = 1'b0;
        end else begin
            lock_cnt++;
            if (lock_cnt >= 40) mmcm_locked = 1'b1;
        end
    end

    // ---------------- behavioural model ----------------
    // Phases are tracked with the edge number at which they began; dwell
    // times are compared as elapsed cycles.
    localparam int P_IDLE = 0, P_ARM = 1, P_WAIT = 2, P_LOCK = 3, P_HOLD = 4;

    int         n, ph, t0, m_sel;
    int         ecnt[2];
    logic [1:0] m_pres, m_mask;
    logic       m_sv, m_mr, m_lo, m_tp;
    logic       smp_t[2][4];
    logic       smp_l[4];

    function automatic logic tog_at(input int i, input int k);
        return (k < 1) ? 1'b0 : smp_t[i][k % 4];
    endfunction

    task automatic model_reset();
        n = 0; ph = P_IDLE; t0 = 0; m_sel = 0;
        m_pres = 2'b00; m_mask = 2'b00;
        ecnt[0] = 0; ecnt[1] = 0;
        m_sv = 1'b0; m_mr = 1'b1; m_lo = 1'b0; m_tp = 1'b0;
    endtask

    task automatic model_step();
        logic       lock_s, tmo;
        logic [1:0] elig, new_p;
        int         cand, nph;
        n++;
        for (int i = 0; i < 2; i++) smp_t[i][n % 4] = src_toggle[i];
        smp_l[n % 4] = mmcm_locked;
        lock_s = (n - 2 >= 1) ? smp_l[(n - 2) % 4] : 1'b0;
        elig = m_pres & ~m_mask;
        cand = -1;
        for (int i = 1; i >= 0; i--) if (elig[i]) cand = i;
        nph = ph;
        tmo = 1'b0;
        case (ph)
            P_IDLE: if (cand >= 0) begin m_sel = cand; nph = P_ARM; end
            P_ARM:  if (n - t0 == RST_CYC) nph = P_WAIT;
            P_WAIT: begin
                if (!m_pres[m_sel]) nph = P_HOLD;
                else if (lock_s) nph = P_LOCK;
                else if (n - t0 == LOCK_TIMEOUT) begin tmo = 1'b1; nph = P_HOLD; end
            end
            P_LOCK: if (!lock_s || !m_pres[m_sel] || (PREEMPT != 0 && cand >= 0 && cand < m_sel))
                        nph = P_HOLD;
            P_HOLD: if (n - t0 == HOLDOFF_CYC) nph = P_IDLE;
            default: nph = P_IDLE;
        endcase
        if (nph != ph) begin ph = nph; t0 = n; end
        m_mask = m_mask & m_pres;
        if (tmo) m_mask[m_sel] = 1'b1;
        new_p = m_pres;
        for (int i = 0; i < 2; i++) begin
            if (n % ACT_WINDOW == 0) begin
                new_p[i] = (ecnt[i] >= ACT_MIN);
                ecnt[i]  = 0;
            end else if (tog_at(i, n - 2) != tog_at(i, n - 3)) begin
                ecnt[i]++;
            end
        end
        m_pres = new_p;
        m_sv = (ph == P_ARM) || (ph == P_WAIT) || (ph == P_LOCK);
        m_mr = (ph == P_IDLE) || (ph == P_ARM) || (ph == P_HOLD);
        m_lo = (ph == P_LOCK);
        m_tp = tmo;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge ref_clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    initial forever begin
        @(negedge ref_clk);
        if (!reset) begin
            check("cycle_outputs",
                  {23'd0, sel, sel_valid, mmcm_reset, locked_out, src_present, src_masked, timeout_pulse},
                  {23'd0, m_sel[0], m_sv, m_mr, m_lo, m_pres, m_mask, m_tp});
        end
    end

    // ---------------- directed sequence ----------------
    localparam int W_SV = 0, W_MR = 1, W_LO = 2, W_TP = 3, W_ML = 4, W_MK0 = 5;

    function automatic logic sig(input int which);
        case (which)
            W_SV:    return sel_valid;
            W_MR:    return mmcm_reset;
            W_LO:    return locked_out;
            W_TP:    return timeout_pulse;
            W_ML:    return mmcm_locked;
            default: return src_masked[0];
        endcase
    endfunction

    task automatic step();
        @(negedge ref_clk);
        #1;
    endtask

    task automatic wait_sig(input int which, input logic val, input int bound, input string nm);
        int k;
        k = 0;
        while ((sig(which) !== val) && (k < bound)) begin
            step();
            k++;
        end
        check(nm, {31'd0, sig(which)}, {31'd0, val});
    endtask

    task automatic check_reset_values(input string nm);
        check({nm, "_sel"},         {31'd0, sel},           32'd0);
        check({nm, "_sel_valid"},   {31'd0, sel_valid},     32'd0);
        check({nm, "_mmcm_reset"},  {31'd0, mmcm_reset},    32'd1);
        check({nm, "_locked_out"},  {31'd0, locked_out},    32'd0);
        check({nm, "_src_present"}, {30'd0, src_present},   32'd0);
        check({nm, "_src_masked"},  {30'd0, src_masked},    32'd0);
        check({nm, "_timeout"},     {31'd0, timeout_pulse}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    initial begin
        int k;
        repeat (3) step();
        check_reset_values("reset");
        reset = 1'b0;

        // Only src 1 alive, MMCM locks 40 cycles after reset release.
        tog_period[1] = 4;
        lock_mode     = 1;
        wait_sig(W_SV, 1'b1, 400, "s1_sel_valid_rise");
        check("s1_sel", {31'd0, sel}, 32'd1);
        k = 0;
        while (mmcm_reset && k < 50) begin k++; step(); end
        check("s1_arm_len", k, RST_CYC);
        wait_sig(W_ML, 1'b1, 200, "s1_mmcm_locked");
        k = 0;
        while (!locked_out && k < 20) begin step(); k++; end
        check("s1_lock_latency", k, 3);

        // src 0 appears: pre-emption, holdoff, reselect src 0.
        tog_period[0] = 4;
        wait_sig(W_SV, 1'b0, 400, "s2_holdoff_entry");
        k = 0;
        while (!sel_valid && k < 100) begin k++; step(); end
        check("s2_gated_len", k, HOLDOFF_CYC + 1);
        check("s2_sel", {31'd0, sel}, 32'd0);
        wait_sig(W_LO, 1'b1, 400, "s2_relock");
        check("s2_sel_locked", {31'd0, sel}, 32'd0);

        // No lock ever: timeout on src 0, mask, fall back to src 1.
        lock_mode = 0;
        do_reset();
        wait_sig(W_SV, 1'b1, 400, "s3_sel_valid");
        check("s3_sel", {31'd0, sel}, 32'd0);
        wait_sig(W_MR, 1'b0, 50, "s3_reset_release");
        k = 0;
        while (!timeout_pulse && k < 300) begin step(); k++; end
        check("s3_timeout_at", k, LOCK_TIMEOUT);
        check("s3_masked", {30'd0, src_masked}, 32'd1);
        step();
        check("s3_pulse_width", {31'd0, timeout_pulse}, 32'd0);
        wait_sig(W_SV, 1'b1, 200, "s3_fallback_valid");
        check("s3_fallback_sel", {31'd0, sel}, 32'd1);
        tog_period[0] = 0;
        wait_sig(W_MK0, 1'b0, 400, "s3_mask0_clear");
        check("s3_present0_gone", {31'd0, src_present[0]}, 32'd0);

        // Locked on src 0, then src 0 stops.
        tog_period[0] = 4;
        lock_mode     = 1;
        do_reset();
        wait_sig(W_LO, 1'b1, 500, "s4_lock0");
        check("s4_sel0", {31'd0, sel}, 32'd0);
        tog_period[0] = 0;
        wait_sig(W_LO, 1'b0, 300, "s4_lock_drop");
        check("s4_present", {30'd0, src_present}, 32'd2);
        wait_sig(W_LO, 1'b1, 400, "s4_lock1");
        check("s4_sel1", {31'd0, sel}, 32'd1);

        // Weak source: at most 3 edges per window.
        tog_period[0] = 21;
        tog_period[1] = 0;
        do_reset();
        repeat (300) step();
        check("s5_present", {30'd0, src_present}, 32'd0);
        check("s5_sel_valid", {31'd0, sel_valid}, 32'd0);
        check("s5_mmcm_reset", {31'd0, mmcm_reset}, 32'd1);

        // Reset while LOCKED, then full restart.
        tog_period[0] = 0;
        tog_period[1] = 4;
        do_reset();
        wait_sig(W_LO, 1'b1, 500, "s6_lock");
        reset = 1'b1;
        #1;
        check_reset_values("s6_midreset");
        repeat (3) step();
        reset = 1'b0;
        wait_sig(W_SV, 1'b1, 400, "s6_restart_valid");
        wait_sig(W_LO, 1'b1, 400, "s6_relock");
        check("s6_sel", {31'd0, sel}, 32'd1);

        repeat (5) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
